// File: rtl/bsg_wormhole_router_adapter_out_pkg.sv
// Shared definitions for the wormhole adapters.
// Holds the default link and packet widths, the flit-count formula, the
// packet layout {payload, len, cord} for the default widths, and the
// receive-adapter state encoding.
package bsg_wormhole_router_adapter_out_pkg;

   localparam int flit_width_gp        = 8;
   localparam int max_payload_width_gp = 17;
   localparam int cord_width_gp        = 4;
   localparam int len_width_gp         = 2;

   // Integer ceiling division, used to size a packet in flits.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   localparam int max_packet_width_gp =
      max_payload_width_gp + len_width_gp + cord_width_gp;
   localparam int max_num_flit_gp = ceil_div(max_packet_width_gp, flit_width_gp);

   // Packet as seen by the endpoint: cord sits at the LSBs.
   typedef struct packed {
      logic [max_payload_width_gp-1:0] payload;
      logic [len_width_gp-1:0]         len;
      logic [cord_width_gp-1:0]        cord;
   } wormhole_packet_s;

   typedef enum logic [0:0] {
      e_recv = 1'b0,
      e_send = 1'b1
   } adapter_state_e;

endpackage

// File: rtl/bsg_wormhole_router_adapter_out_counter.sv
// Flit slot counter for the receive adapter.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset (count returns to 0)
//   clear_i  - return count to 0 (takes priority over up_i)
//   up_i     - increment count; holds once max_val_p is reached
//   count_o  - current count
module bsg_wormhole_router_adapter_out_counter #(
   parameter int width_p   = 2,
   parameter int max_val_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] count_reg;

   // Saturating so an over-long len cannot walk the write pointer past the
   // last buffer slot.
   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         count_reg <= '0;
      end else if (up_i && (count_reg != width_p'(max_val_p))) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count_o = count_reg;

endmodule

// File: rtl/bsg_wormhole_router_adapter_out.sv
// Receive-side wormhole adapter: collects flits from a ready_and link and
// presents the reassembled packet {payload, len, cord} on a valid/yumi port.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset
//   link_i   - {v, ready_and_rev (unused), data} from the router egress
//   link_o   - {v=0, ready_and_rev, data=0} back to the router
//   packet_o - reassembled packet, flit k at bits [k*flit_width_p +: flit_width_p]
//   v_o      - packet_o valid
//   yumi_i   - consumer takes the packet this cycle
module bsg_wormhole_router_adapter_out
   import bsg_wormhole_router_adapter_out_pkg::*;
#(
   parameter int flit_width_p        = flit_width_gp,
   parameter int max_payload_width_p = max_payload_width_gp,
   parameter int cord_width_p        = cord_width_gp,
   parameter int len_width_p         = len_width_gp,
   localparam int max_packet_width_lp = max_payload_width_p + len_width_p + cord_width_p,
   localparam int max_num_flit_lp     = ceil_div(max_packet_width_lp, flit_width_p)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [flit_width_p+1:0]        link_i,
   output logic [flit_width_p+1:0]        link_o,
   output logic [max_packet_width_lp-1:0] packet_o,
   output logic                           v_o,
   input  logic                           yumi_i
);

   localparam int cnt_width_lp = (max_num_flit_lp > 1) ? $clog2(max_num_flit_lp) : 1;
   localparam int cmp_width_lp = (cnt_width_lp > len_width_p) ? cnt_width_lp : len_width_p;

   // The header flit must carry both len and cord.
   if (len_width_p + cord_width_p > flit_width_p) begin : g_hdr_check
      $error("len_width_p + cord_width_p exceeds flit_width_p");
   end

   adapter_state_e state_reg;
   logic [cnt_width_lp-1:0] cnt;
   logic [len_width_p-1:0]  len_reg;
   logic [len_width_p-1:0]  hdr_len;
   logic [len_width_p-1:0]  eff_len;
   logic [flit_width_p-1:0] link_data;
   logic [max_packet_width_lp-1:0] packet_buf;
   logic link_v;
   logic ready_and;
   logic accept;
   logic last;
   logic consume;
   logic unused_ready_and_rev;

   assign link_v               = link_i[flit_width_p+1];
   assign unused_ready_and_rev = link_i[flit_width_p];
   assign link_data            = link_i[flit_width_p-1:0];

   assign ready_and = (state_reg == e_recv) && !reset_i;
   assign accept    = link_v && ready_and;
   assign consume   = (state_reg == e_send) && yumi_i;

   // On the header beat len_reg is not loaded yet, so use the len field of
   // the incoming flit directly; this lets a single-flit packet finish at once.
   assign hdr_len = link_data[cord_width_p +: len_width_p];
   assign eff_len = (cnt == '0) ? hdr_len : len_reg;
   assign last    = accept && (cmp_width_lp'(eff_len) == cmp_width_lp'(cnt));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg <= e_recv;
         len_reg   <= '0;
      end else begin
         if (accept && (cnt == '0)) begin
            len_reg <= hdr_len;
         end
         case (state_reg)
            e_recv:  if (last)   state_reg <= e_send;
            e_send:  if (yumi_i) state_reg <= e_recv;
            default:             state_reg <= e_recv;
         endcase
      end
   end

   bsg_wormhole_router_adapter_out_counter #(
      .width_p  (cnt_width_lp),
      .max_val_p(max_num_flit_lp - 1)
   ) cnt_inst (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clear_i(last),
      .up_i   (accept && !last),
      .count_o(cnt)
   );

   // One register slice per flit slot, written when cnt selects it. The top
   // slice is trimmed to the bits that actually belong to the packet. All
   // slices clear when a packet is taken so short packets read zero above
   // their last flit.
   for (genvar gi = 0; gi < max_num_flit_lp; gi++) begin : g_slice
      localparam int lo_lp = gi * flit_width_p;
      localparam int w_lp  = (max_packet_width_lp - lo_lp < flit_width_p)
                           ? (max_packet_width_lp - lo_lp) : flit_width_p;

      logic [w_lp-1:0] slice_reg;
      logic            we;

      assign we = accept && (cnt == cnt_width_lp'(gi));

      always_ff @(posedge clk_i) begin
         if (reset_i || consume) begin
            slice_reg <= '0;
         end else if (we) begin
            slice_reg <= link_data[w_lp-1:0];
         end
      end

      assign packet_buf[lo_lp +: w_lp] = slice_reg;
   end

   assign v_o      = (state_reg == e_send) && !reset_i;
   assign packet_o = reset_i ? '0 : packet_buf;
   assign link_o   = {1'b0, ready_and, {flit_width_p{1'b0}}};

   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      yumi_i |-> v_o);

   a_len_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
      (accept && (cnt == '0)) |-> (int'(hdr_len) <= max_num_flit_lp - 1));

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_out.sv
module tb_bsg_wormhole_router_adapter_out;
   import bsg_wormhole_router_adapter_out_pkg::*;

   localparam int NUM_RAND = 1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        lv;
   logic [7:0]  ld;
   logic [9:0]  link_i;
   logic [9:0]  link_o;
   logic [22:0] packet_o;
   logic        v_o;
   logic        yumi;
   logic        ready;
   logic        abort = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pkt = 0;
   logic [22:0] exp_q[$];

   assign link_i = {lv, 1'b0, ld};
   assign ready  = link_o[8];

   always #5 clk = ~clk;

   bsg_wormhole_router_adapter_out dut (
      .clk_i   (clk),
      .reset_i (reset),
      .link_i  (link_i),
      .link_o  (link_o),
      .packet_o(packet_o),
      .v_o     (v_o),
      .yumi_i  (yumi)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Compare packet_o against the oldest expected packet.
   task automatic pop_check(input string name);
      logic [22:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got packet %h, required none (queue empty)", name, packet_o);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(packet_o), 32'(e));
         $display("pkt %0d %s: packet_o=%h expected=%h", n_pkt, name, packet_o, e);
         n_pkt++;
      end
   endtask

   typedef struct {
      int          n;
      logic [23:0] flits;
      int          gap;
      logic [22:0] exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      reset = 1'b1;
      lv    = 1'b0;
      ld    = 8'h00;
      yumi  = 1'b0;

      tbl[0] = '{n: 1, flits: 24'h00000A, gap: 0, exp: 23'h00000A};
      tbl[1] = '{n: 3, flits: 24'h123425, gap: 0, exp: 23'h123425};
      tbl[2] = '{n: 2, flits: 24'h00FF15, gap: 3, exp: 23'h00FF15};
      tbl[3] = '{n: 2, flits: 24'h00AB17, gap: 1, exp: 23'h00AB17};
      tbl[4] = '{n: 3, flits: 24'hFFFF2F, gap: 2, exp: 23'h7FFF2F};
      tbl[5] = '{n: 1, flits: 24'h0000C6, gap: 0, exp: 23'h0000C6};

      // Reset state
      repeat (3) tick();
      check("rst_v_o", 32'(v_o), 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_packet", 32'(packet_o), 0);
      check("link_o_v_data", {23'h0, link_o[9], link_o[7:0]}, 0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(ready), 1);
      check("post_rst_v_o", 32'(v_o), 0);

      // Table-driven packets
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(tbl[i].exp);
         for (int k = 0; k < tbl[i].n; k++) begin
            lv = 1'b1;
            ld = tbl[i].flits[k*8 +: 8];
            tick();
            lv = 1'b0;
            if (k < tbl[i].n - 1) begin
               check("vec_mid_v_o", 32'(v_o), 0);
               check("vec_mid_ready", 32'(ready), 1);
               repeat (tbl[i].gap) tick();
            end
         end
         check("vec_v_o", 32'(v_o), 1);
         check("vec_ready_low", 32'(ready), 0);
         pop_check("vec_packet");
         yumi = 1'b1;
         tick();
         yumi = 1'b0;
         check("vec_after_yumi_v_o", 32'(v_o), 0);
         check("vec_after_yumi_ready", 32'(ready), 1);
      end

      // Backpressure: packet held while the next flit waits on the link
      exp_q.push_back(23'h123425);
      lv = 1'b1;
      ld = 8'h25; tick();
      ld = 8'h34; tick();
      ld = 8'h12; tick();
      ld = 8'h0B;
      for (int c = 0; c < 5; c++) begin
         check("bp_ready", 32'(ready), 0);
         check("bp_v_o", 32'(v_o), 1);
         check("bp_packet_stable", 32'(packet_o), 32'h123425);
         tick();
      end
      pop_check("bp_packet");
      yumi = 1'b1;
      tick();
      yumi = 1'b0;
      check("bp_release_v_o", 32'(v_o), 0);
      check("bp_release_ready", 32'(ready), 1);
      exp_q.push_back(23'h00000B);
      tick();
      lv = 1'b0;
      check("bp_next_v_o", 32'(v_o), 1);
      pop_check("bp_next_packet");
      yumi = 1'b1;
      tick();
      yumi = 1'b0;

      // Reset mid-packet
      lv = 1'b1;
      ld = 8'h25; tick();
      ld = 8'h34; tick();
      lv = 1'b0;
      reset = 1'b1;
      #1;
      check("rstpkt_v_o", 32'(v_o), 0);
      check("rstpkt_ready", 32'(ready), 0);
      tick();
      reset = 1'b0;
      #1;
      check("rstpkt_after_packet", 32'(packet_o), 0);
      check("rstpkt_after_v_o", 32'(v_o), 0);
      check("rstpkt_after_ready", 32'(ready), 1);
      exp_q.push_back(23'h00000C);
      lv = 1'b1;
      ld = 8'h0C;
      tick();
      lv = 1'b0;
      check("rstpkt_new_v_o", 32'(v_o), 1);
      pop_check("rstpkt_new_packet");

      // Reset while a packet is pending
      reset = 1'b1;
      #1;
      check("rstsend_v_o", 32'(v_o), 0);
      check("rstsend_packet", 32'(packet_o), 0);
      tick();
      reset = 1'b0;
      #1;
      check("rstsend_after_v_o", 32'(v_o), 0);
      check("rstsend_after_ready", 32'(ready), 1);

      // Random back-to-back packets against the scoreboard
      fork
         begin : drv
            for (int p = 0; p < NUM_RAND && !abort; p++) begin
               int          len;
               logic [23:0] fl;
               logic [23:0] e;
               len = int'($urandom_range(0, 2));
               fl = 24'($urandom);
               fl[5:4] = 2'(len);
               e = '0;
               for (int k = 0; k <= len; k++) e[k*8 +: 8] = fl[k*8 +: 8];
               exp_q.push_back(e[22:0]);
               for (int k = 0; k <= len && !abort; k++) begin
                  logic acc;
                  int   t;
                  if ($urandom_range(0, 3) == 0) begin
                     lv = 1'b0;
                     repeat ($urandom_range(1, 3)) tick();
                  end
                  lv = 1'b1;
                  ld = fl[k*8 +: 8];
                  t = 0;
                  do begin
                     acc = ready;
                     tick();
                     t++;
                  end while (!acc && t < 200);
                  if (!acc) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL rand_accept_timeout: got ready=0 for 200 cycles, required 1");
                     abort = 1'b1;
                  end
               end
               lv = 1'b0;
            end
         end
         begin : cons
            for (int p = 0; p < NUM_RAND && !abort; p++) begin
               int t;
               t = 0;
               while (!v_o && t < 500 && !abort) begin
                  tick();
                  t++;
               end
               if (!v_o) begin
                  if (!abort) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL rand_v_o_timeout: got v_o=0 for 500 cycles, required 1");
                  end
                  abort = 1'b1;
               end else begin
                  repeat ($urandom_range(0, 3)) tick();
                  pop_check("rand_packet");
                  yumi = 1'b1;
                  tick();
                  yumi = 1'b0;
               end
            end
         end
      join

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
